// File: rtl/exception_sequencer_pkg.sv
// Shared word, mode and exception-encoding definitions for the nnARM exception path.
// Build macro HIGH_VECTORS_EN moves the vector table base from 0x00000000 to 0xFFFF0000.
`ifndef EXCEPTION_SEQUENCER_DEFINES
`define EXCEPTION_SEQUENCER_DEFINES
`define WordWidth 32
`define WordZero 32'h0000_0000
`define MODE_USER 5'b10000
`define MODE_FIQ 5'b10001
`define MODE_IRQ 5'b10010
`define MODE_SVC 5'b10011
`define MODE_ABT 5'b10111
`define MODE_UND 5'b11011
`define EXC_NONE 3'd0
`define EXC_UND 3'd1
`define EXC_SWI 3'd2
`define EXC_PABT 3'd3
`define EXC_DABT 3'd4
`define EXC_IRQ 3'd6
`define EXC_FIQ 3'd7
`define VEC_OFF_UND 32'h0000_0004
`define VEC_OFF_SWI 32'h0000_0008
`define VEC_OFF_PABT 32'h0000_000C
`define VEC_OFF_DABT 32'h0000_0010
`define VEC_OFF_IRQ 32'h0000_0018
`define VEC_OFF_FIQ 32'h0000_001C
`ifdef HIGH_VECTORS_EN
`define VECTOR_BASE 32'hFFFF_0000
`else
`define VECTOR_BASE 32'h0000_0000
`endif
`endif

package exception_sequencer_pkg;

  localparam logic [`WordWidth-1:0] VECTOR_BASE = `VECTOR_BASE;

  typedef enum logic [2:0] {
    EXC_NONE = `EXC_NONE,
    EXC_UND  = `EXC_UND,
    EXC_SWI  = `EXC_SWI,
    EXC_PABT = `EXC_PABT,
    EXC_DABT = `EXC_DABT,
    EXC_IRQ  = `EXC_IRQ,
    EXC_FIQ  = `EXC_FIQ
  } exc_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_VECTOR,
    ST_DRAIN
  } seq_state_t;

  // Processor mode entered for each exception type.
  function automatic logic [4:0] mode_for(input exc_type_t t);
    case (t)
      EXC_FIQ:  mode_for = `MODE_FIQ;
      EXC_IRQ:  mode_for = `MODE_IRQ;
      EXC_SWI:  mode_for = `MODE_SVC;
      EXC_PABT: mode_for = `MODE_ABT;
      EXC_DABT: mode_for = `MODE_ABT;
      EXC_UND:  mode_for = `MODE_UND;
      default:  mode_for = `MODE_USER;
    endcase
  endfunction

  // Offset of each exception's slot in the vector table.
  function automatic logic [`WordWidth-1:0] vector_offset(input exc_type_t t);
    case (t)
      EXC_UND:  vector_offset = `VEC_OFF_UND;
      EXC_SWI:  vector_offset = `VEC_OFF_SWI;
      EXC_PABT: vector_offset = `VEC_OFF_PABT;
      EXC_DABT: vector_offset = `VEC_OFF_DABT;
      EXC_IRQ:  vector_offset = `VEC_OFF_IRQ;
      EXC_FIQ:  vector_offset = `VEC_OFF_FIQ;
      default:  vector_offset = `WordZero;
    endcase
  endfunction

endpackage

// File: rtl/exception_sequencer_priority.sv
// Combinational masking and fixed-priority selection of pending exception requests.
module exception_priority_encoder
  import exception_sequencer_pkg::*;
(
  input  logic      fiq,
  input  logic      irq,
  input  logic      data_abort,
  input  logic      prefetch_abort,
  input  logic      undefined,
  input  logic      swi,
  input  logic      mask_i,
  input  logic      mask_f,
  output logic      valid,
  output exc_type_t exc_type
);

  logic fiq_ok;
  logic irq_ok;

  assign fiq_ok = fiq & ~mask_f;
  assign irq_ok = irq & ~mask_i;

  // Highest-priority eligible request wins; Undefined beats SWI if both appear.
  always_comb begin
    valid    = 1'b1;
    exc_type = EXC_NONE;
    if (data_abort)          exc_type = EXC_DABT;
    else if (fiq_ok)         exc_type = EXC_FIQ;
    else if (irq_ok)         exc_type = EXC_IRQ;
    else if (prefetch_abort) exc_type = EXC_PABT;
    else if (undefined)      exc_type = EXC_UND;
    else if (swi)            exc_type = EXC_SWI;
    else                     valid    = 1'b0;
  end

endmodule

// File: rtl/exception_sequencer.sv
// Exception-entry controller: arbitrates requests, writes CPSR/SPSR/LR through the
// PSR block, redirects fetch to the vector and holds the pipeline until entry completes.
// Build macro HIGH_VECTORS_EN selects the high vector table base (0xFFFF0000).
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_FIQ,
  input  logic        in_IRQ,
  input  logic        in_DataAbort,
  input  logic        in_PrefetchAbort,
  input  logic        in_Undefined,
  input  logic        in_SWI,
  input  logic [31:0] in_ExcPC,
  input  logic [31:0] in_CPSR,
  output logic        out_IfChangeState,
  output logic [4:0]  out_ChangeStateAction,
  output logic        out_CPSRWriteEnable,
  output logic [31:0] out_CPSRWriteValue,
  output logic        out_SPSRWriteEnable,
  output logic [31:0] out_SPSRWriteValue,
  output logic        out_LRWriteEnable,
  output logic [31:0] out_LRWriteValue,
  output logic        out_BranchEnable,
  output logic [31:0] out_BranchAddress,
  output logic        out_Flush,
  output logic        out_Stall
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  seq_state_t  state, state_next;
  exc_type_t   exc_type_q, exc_type_next, req_type;
  logic        req_valid;
  logic [3:0]  drain_cnt, drain_cnt_next;
  logic [4:0]  req_mode;
  logic        change_next, cpsr_we_next, spsr_we_next, lr_we_next;
  logic        branch_next, flush_next, stall_next;
  logic [4:0]  action_next;
  logic [31:0] cpsr_val_next, spsr_val_next, lr_val_next, baddr_next;

  exception_priority_encoder u_priority (
    .fiq            (in_FIQ),
    .irq            (in_IRQ),
    .data_abort     (in_DataAbort),
    .prefetch_abort (in_PrefetchAbort),
    .undefined      (in_Undefined),
    .swi            (in_SWI),
    .mask_i         (in_CPSR[7]),
    .mask_f         (in_CPSR[6]),
    .valid          (req_valid),
    .exc_type       (req_type)
  );

  assign req_mode = mode_for(req_type);

  // Next state and next registered outputs; the PSR/LR value registers double as
  // the latched old CPSR and return address, so they only change on a capture.
  always_comb begin
    state_next     = state;
    exc_type_next  = exc_type_q;
    drain_cnt_next = drain_cnt;
    change_next    = 1'b0;
    cpsr_we_next   = 1'b0;
    spsr_we_next   = 1'b0;
    lr_we_next     = 1'b0;
    branch_next    = 1'b0;
    flush_next     = 1'b0;
    action_next    = out_ChangeStateAction;
    cpsr_val_next  = out_CPSRWriteValue;
    spsr_val_next  = out_SPSRWriteValue;
    lr_val_next    = out_LRWriteValue;
    baddr_next     = out_BranchAddress;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_next    = ST_ENTRY;
          exc_type_next = req_type;
          change_next   = 1'b1;
          cpsr_we_next  = 1'b1;
          spsr_we_next  = 1'b1;
          lr_we_next    = 1'b1;
          action_next   = req_mode;
          cpsr_val_next = {in_CPSR[31:8], 1'b1,
                           (req_type == EXC_FIQ) ? 1'b1 : in_CPSR[6],
                           1'b0, req_mode};
          spsr_val_next = in_CPSR;
          lr_val_next   = in_ExcPC + ((req_type == EXC_DABT) ? 32'd8 : 32'd4);
        end
      end
      ST_ENTRY: begin
        state_next  = ST_VECTOR;
        branch_next = 1'b1;
        flush_next  = 1'b1;
        baddr_next  = VECTOR_BASE + vector_offset(exc_type_q);
      end
      ST_VECTOR: begin
        state_next     = ST_DRAIN;
        drain_cnt_next = DRAIN_LOAD;
      end
      ST_DRAIN: begin
        if (drain_cnt < 4'd2) begin
          state_next     = ST_IDLE;
          drain_cnt_next = 4'd0;
        end else begin
          drain_cnt_next = drain_cnt - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    stall_next = (state_next != ST_IDLE);
  end

  // State, latches and all outputs are registered; reset abandons any entry in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                 <= ST_IDLE;
      exc_type_q            <= EXC_NONE;
      drain_cnt             <= 4'd0;
      out_IfChangeState     <= 1'b0;
      out_ChangeStateAction <= 5'd0;
      out_CPSRWriteEnable   <= 1'b0;
      out_CPSRWriteValue    <= 32'd0;
      out_SPSRWriteEnable   <= 1'b0;
      out_SPSRWriteValue    <= 32'd0;
      out_LRWriteEnable     <= 1'b0;
      out_LRWriteValue      <= 32'd0;
      out_BranchEnable      <= 1'b0;
      out_BranchAddress     <= 32'd0;
      out_Flush             <= 1'b0;
      out_Stall             <= 1'b0;
    end else begin
      state                 <= state_next;
      exc_type_q            <= exc_type_next;
      drain_cnt             <= drain_cnt_next;
      out_IfChangeState     <= change_next;
      out_ChangeStateAction <= action_next;
      out_CPSRWriteEnable   <= cpsr_we_next;
      out_CPSRWriteValue    <= cpsr_val_next;
      out_SPSRWriteEnable   <= spsr_we_next;
      out_SPSRWriteValue    <= spsr_val_next;
      out_LRWriteEnable     <= lr_we_next;
      out_LRWriteValue      <= lr_val_next;
      out_BranchEnable      <= branch_next;
      out_BranchAddress     <= baddr_next;
      out_Flush             <= flush_next;
      out_Stall             <= stall_next;
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed testbench for exception_sequencer (DRAIN_CYCLES = 2).
// Build macro HIGH_VECTORS_EN switches the expected vector base to 0xFFFF0000.
module tb_exception_sequencer;

`ifdef HIGH_VECTORS_EN
  localparam logic [31:0] VB = 32'hFFFF_0000;
`else
  localparam logic [31:0] VB = 32'h0000_0000;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_FIQ, in_IRQ, in_DataAbort, in_PrefetchAbort, in_Undefined, in_SWI;
  logic [31:0] in_ExcPC, in_CPSR;
  logic        out_IfChangeState, out_CPSRWriteEnable, out_SPSRWriteEnable;
  logic        out_LRWriteEnable, out_BranchEnable, out_Flush, out_Stall;
  logic [4:0]  out_ChangeStateAction;
  logic [31:0] out_CPSRWriteValue, out_SPSRWriteValue, out_LRWriteValue, out_BranchAddress;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  exception_sequencer #(.DRAIN_CYCLES(2)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .in_FIQ                (in_FIQ),
    .in_IRQ                (in_IRQ),
    .in_DataAbort          (in_DataAbort),
    .in_PrefetchAbort      (in_PrefetchAbort),
    .in_Undefined          (in_Undefined),
    .in_SWI                (in_SWI),
    .in_ExcPC              (in_ExcPC),
    .in_CPSR               (in_CPSR),
    .out_IfChangeState     (out_IfChangeState),
    .out_ChangeStateAction (out_ChangeStateAction),
    .out_CPSRWriteEnable   (out_CPSRWriteEnable),
    .out_CPSRWriteValue    (out_CPSRWriteValue),
    .out_SPSRWriteEnable   (out_SPSRWriteEnable),
    .out_SPSRWriteValue    (out_SPSRWriteValue),
    .out_LRWriteEnable     (out_LRWriteEnable),
    .out_LRWriteValue      (out_LRWriteValue),
    .out_BranchEnable      (out_BranchEnable),
    .out_BranchAddress     (out_BranchAddress),
    .out_Flush             (out_Flush),
    .out_Stall             (out_Stall)
  );

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {out_IfChangeState, out_CPSRWriteEnable, out_SPSRWriteEnable,
            out_LRWriteEnable, out_BranchEnable, out_Flush};
  endfunction

  function automatic logic [139:0] all_outputs();
    return {out_IfChangeState, out_ChangeStateAction, out_CPSRWriteEnable, out_CPSRWriteValue,
            out_SPSRWriteEnable, out_SPSRWriteValue, out_LRWriteEnable, out_LRWriteValue,
            out_BranchEnable, out_BranchAddress, out_Flush, out_Stall};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    {in_FIQ, in_IRQ, in_DataAbort, in_PrefetchAbort, in_Undefined, in_SWI} = 6'b0;
    in_ExcPC = 32'h0;
    in_CPSR  = 32'h0000_00D3;
    repeat (3) @(negedge clock);
    tests_run++;
    if (all_outputs() !== 140'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_held: got %h required 0", all_outputs());
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (all_outputs() !== 140'b0 || out_Stall !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_idle_%0d: got %h required 0", i, all_outputs());
      end
    end
  endtask

  task automatic test_swi();
    @(negedge clock);
    in_SWI = 1'b1; in_CPSR = 32'h0000_00D0; in_ExcPC = 32'h0000_0100;
    tick();
    in_SWI = 1'b0; in_CPSR = 32'h0000_00D3;
    tests_run++;
    if (strobes() !== 6'b111100 || out_Stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL swi_entry_strobes: got %b/%b required 111100/1", strobes(), out_Stall);
    end
    tests_run++;
    if (out_ChangeStateAction !== 5'b10011 || out_CPSRWriteValue !== 32'h0000_00D3) begin
      tests_failed++;
      $display("[TB] FAIL swi_entry_mode: got %b %h required 10011 000000d3",
               out_ChangeStateAction, out_CPSRWriteValue);
    end
    tests_run++;
    if (out_SPSRWriteValue !== 32'h0000_00D0 || out_LRWriteValue !== 32'h0000_0104) begin
      tests_failed++;
      $display("[TB] FAIL swi_entry_spsr_lr: got %h %h required 000000d0 00000104",
               out_SPSRWriteValue, out_LRWriteValue);
    end
    tick();
    tests_run++;
    if (strobes() !== 6'b000011 || out_BranchAddress !== VB + 32'h08 || out_Stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL swi_vector: got %b %h %b required 000011 %h 1",
               strobes(), out_BranchAddress, out_Stall, VB + 32'h08);
    end
    tick();
    tests_run++;
    if (strobes() !== 6'b000000 || out_Stall !== 1'b1 || out_BranchAddress !== VB + 32'h08) begin
      tests_failed++;
      $display("[TB] FAIL swi_drain1: got %b %b %h required 000000 1 %h",
               strobes(), out_Stall, out_BranchAddress, VB + 32'h08);
    end
    tick();
    tests_run++;
    if (out_Stall !== 1'b1 || out_LRWriteValue !== 32'h0000_0104) begin
      tests_failed++;
      $display("[TB] FAIL swi_drain2: got %b %h required 1 00000104", out_Stall, out_LRWriteValue);
    end
    tick();
    tests_run++;
    if (out_Stall !== 1'b0 || strobes() !== 6'b000000) begin
      tests_failed++;
      $display("[TB] FAIL swi_release: got %b %b required 0 000000", out_Stall, strobes());
    end
  endtask

  task automatic test_fiq_over_irq();
    @(negedge clock);
    in_FIQ = 1'b1; in_IRQ = 1'b1; in_CPSR = 32'h0000_0010; in_ExcPC = 32'h0000_0200;
    tick();
    in_FIQ = 1'b0; in_IRQ = 1'b0; in_CPSR = 32'h0000_00D1;
    tests_run++;
    if (out_IfChangeState !== 1'b1 || out_ChangeStateAction !== 5'b10001 ||
        out_CPSRWriteValue !== 32'h0000_00D1) begin
      tests_failed++;
      $display("[TB] FAIL fiq_entry_mode: got %b %b %h required 1 10001 000000d1",
               out_IfChangeState, out_ChangeStateAction, out_CPSRWriteValue);
    end
    tests_run++;
    if (out_SPSRWriteValue !== 32'h0000_0010 || out_LRWriteValue !== 32'h0000_0204) begin
      tests_failed++;
      $display("[TB] FAIL fiq_entry_spsr_lr: got %h %h required 00000010 00000204",
               out_SPSRWriteValue, out_LRWriteValue);
    end
    tick();
    tests_run++;
    if (out_BranchEnable !== 1'b1 || out_BranchAddress !== VB + 32'h1C) begin
      tests_failed++;
      $display("[TB] FAIL fiq_vector: got %b %h required 1 %h",
               out_BranchEnable, out_BranchAddress, VB + 32'h1C);
    end
    repeat (3) tick();
    tests_run++;
    if (out_Stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fiq_release: got %b required 0", out_Stall);
    end
  endtask

  task automatic test_irq_masked();
    @(negedge clock);
    in_IRQ = 1'b1; in_CPSR = 32'h0000_0090; in_ExcPC = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (out_Stall !== 1'b0 || out_IfChangeState !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL irq_masked_%0d: got %b %b required 0 0", i, out_Stall, out_IfChangeState);
      end
    end
    @(negedge clock);
    in_CPSR = 32'h0000_0010;
    tick();
    in_IRQ = 1'b0; in_CPSR = 32'h0000_0092;
    tests_run++;
    if (out_ChangeStateAction !== 5'b10010 || out_CPSRWriteValue !== 32'h0000_0092 ||
        out_LRWriteValue !== 32'h0000_0404) begin
      tests_failed++;
      $display("[TB] FAIL irq_entry: got %b %h %h required 10010 00000092 00000404",
               out_ChangeStateAction, out_CPSRWriteValue, out_LRWriteValue);
    end
    tick();
    tests_run++;
    if (out_BranchEnable !== 1'b1 || out_BranchAddress !== VB + 32'h18) begin
      tests_failed++;
      $display("[TB] FAIL irq_vector: got %b %h required 1 %h",
               out_BranchEnable, out_BranchAddress, VB + 32'h18);
    end
    repeat (3) tick();
  endtask

  task automatic test_fiq_during_irq();
    @(negedge clock);
    in_IRQ = 1'b1; in_CPSR = 32'h0000_0010; in_ExcPC = 32'h0000_0500;
    tick();
    in_IRQ = 1'b0; in_CPSR = 32'h0000_0092; in_FIQ = 1'b1;
    tick();
    tests_run++;
    if (out_IfChangeState !== 1'b0 || out_BranchAddress !== VB + 32'h18) begin
      tests_failed++;
      $display("[TB] FAIL fiq_pending_vector: got %b %h required 0 %h",
               out_IfChangeState, out_BranchAddress, VB + 32'h18);
    end
    repeat (3) tick();
    tests_run++;
    if (out_Stall !== 1'b0 || out_IfChangeState !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fiq_pending_idle: got %b %b required 0 0", out_Stall, out_IfChangeState);
    end
    tick();
    in_FIQ = 1'b0; in_CPSR = 32'h0000_00D1;
    tests_run++;
    if (out_IfChangeState !== 1'b1 || out_ChangeStateAction !== 5'b10001 ||
        out_SPSRWriteValue !== 32'h0000_0092 || out_CPSRWriteValue !== 32'h0000_00D1) begin
      tests_failed++;
      $display("[TB] FAIL fiq_after_irq_entry: got %b %b %h %h required 1 10001 00000092 000000d1",
               out_IfChangeState, out_ChangeStateAction, out_SPSRWriteValue, out_CPSRWriteValue);
    end
    tick();
    tests_run++;
    if (out_BranchAddress !== VB + 32'h1C) begin
      tests_failed++;
      $display("[TB] FAIL fiq_after_irq_vector: got %h required %h", out_BranchAddress, VB + 32'h1C);
    end
    repeat (3) tick();
  endtask

  task automatic test_dabt_wrap();
    @(negedge clock);
    in_DataAbort = 1'b1; in_Undefined = 1'b1; in_CPSR = 32'h0000_0010; in_ExcPC = 32'hFFFF_FFFC;
    tick();
    in_DataAbort = 1'b0; in_Undefined = 1'b0; in_CPSR = 32'h0000_0097;
    tests_run++;
    if (out_ChangeStateAction !== 5'b10111 || out_LRWriteValue !== 32'h0000_0004 ||
        out_CPSRWriteValue !== 32'h0000_0097) begin
      tests_failed++;
      $display("[TB] FAIL dabt_entry: got %b %h %h required 10111 00000004 00000097",
               out_ChangeStateAction, out_LRWriteValue, out_CPSRWriteValue);
    end
    tick();
    tests_run++;
    if (out_BranchAddress !== VB + 32'h10 || out_Flush !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL dabt_vector: got %h %b required %h 1", out_BranchAddress, out_Flush, VB + 32'h10);
    end
    repeat (3) tick();
  endtask

  task automatic test_undef_over_swi();
    @(negedge clock);
    in_Undefined = 1'b1; in_SWI = 1'b1; in_CPSR = 32'h0000_001F; in_ExcPC = 32'h0000_0300;
    tick();
    tests_run++;
    if (out_ChangeStateAction !== 5'b11011 || out_LRWriteValue !== 32'h0000_0304 ||
        out_CPSRWriteValue !== 32'h0000_009B) begin
      tests_failed++;
      $display("[TB] FAIL und_entry: got %b %h %h required 11011 00000304 0000009b",
               out_ChangeStateAction, out_LRWriteValue, out_CPSRWriteValue);
    end
    tick();
    tests_run++;
    if (out_IfChangeState !== 1'b0 || out_BranchAddress !== VB + 32'h04) begin
      tests_failed++;
      $display("[TB] FAIL und_vector: got %b %h required 0 %h", out_IfChangeState, out_BranchAddress, VB + 32'h04);
    end
    tick();
    in_Undefined = 1'b0; in_SWI = 1'b0; in_CPSR = 32'h0000_009B;
    tests_run++;
    if (out_IfChangeState !== 1'b0 || out_Stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL und_sync_ignored: got %b %b required 0 1", out_IfChangeState, out_Stall);
    end
    repeat (2) tick();
    @(negedge clock);
    in_PrefetchAbort = 1'b1; in_CPSR = 32'h0000_0010; in_ExcPC = 32'h0000_0600;
    tick();
    in_PrefetchAbort = 1'b0;
    tests_run++;
    if (out_ChangeStateAction !== 5'b10111 || out_LRWriteValue !== 32'h0000_0604) begin
      tests_failed++;
      $display("[TB] FAIL pabt_entry: got %b %h required 10111 00000604", out_ChangeStateAction, out_LRWriteValue);
    end
    tick();
    tests_run++;
    if (out_BranchAddress !== VB + 32'h0C) begin
      tests_failed++;
      $display("[TB] FAIL pabt_vector: got %h required %h", out_BranchAddress, VB + 32'h0C);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_in_vector();
    @(negedge clock);
    in_SWI = 1'b1; in_CPSR = 32'h0000_00D0; in_ExcPC = 32'h0000_0700;
    tick();
    in_SWI = 1'b0;
    tick();
    tests_run++;
    if (out_BranchEnable !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_pre_vector: got %b required 1", out_BranchEnable);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (all_outputs() !== 140'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_sequence: got %h required 0", all_outputs());
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (out_BranchEnable !== 1'b0 || out_Stall !== 1'b0 || out_IfChangeState !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rst_after_release_%0d: got %b %b %b required 0 0 0",
                 i, out_BranchEnable, out_Stall, out_IfChangeState);
      end
    end
  endtask

  initial begin
    test_reset();
    test_swi();
    test_fiq_over_irq();
    test_irq_masked();
    test_fiq_during_irq();
    test_dabt_wrap();
    test_undef_over_swi();
    test_reset_in_vector();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
